// File: rtl/nibble_add_sequencer_pkg.sv
// Shared definitions for the nibble add sequencer: nibble width, FSM encoding
// and the nibble data type.
package adder_seq_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ADD  = 2'd2,
      DONE = 2'd3
   } seq_state_t;

   typedef logic [NIB_W-1:0] nibble_t;

endpackage

// File: rtl/nibble_add_sequencer.sv
// Feeds operand nibbles LSB-first through an external 4-bit adder, chaining the
// carry between passes and assembling the wide sum plus final carry-out.
module nibble_add_sequencer
   import adder_seq_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start_i,
   input  logic                       cin_i,
   input  logic [NIB_W-1:0]           a_nib_i,
   input  logic [NIB_W-1:0]           b_nib_i,
   input  logic                       nib_valid_i,
   output logic                       nib_ready_o,
   output logic [NIB_W-1:0]           fa_a_o,
   output logic [NIB_W-1:0]           fa_b_o,
   output logic                       fa_cin_o,
   input  logic [NIB_W-1:0]           fa_sum_i,
   input  logic                       fa_cout_i,
   output logic [NIB_W*NIBBLES-1:0]   result_o,
   output logic                       carry_o,
   output logic                       busy_o,
   output logic                       done_o
);

   localparam int               CNT_W    = $clog2(NIBBLES) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

   seq_state_t                r_state;
   seq_state_t                w_next_state;
   nibble_t                   r_a;
   nibble_t                   r_b;
   logic                      r_carry;
   logic [CNT_W-1:0]          r_count;
   logic [NIB_W*NIBBLES-1:0]  r_result;

   // State, nibble counter, operand latches, running carry and result assembly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_carry  <= 1'b0;
         r_count  <= '0;
         r_result <= '0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            IDLE: begin
               if (start_i) begin
                  r_carry  <= cin_i;
                  r_count  <= '0;
                  r_result <= '0;
               end
            end
            LOAD: begin
               if (nib_valid_i) begin
                  r_a <= a_nib_i;
                  r_b <= b_nib_i;
               end
            end
            ADD: begin
               // The adder settles within the cycle, so its sum lands in slot r_count.
               for (int k = 0; k < NIBBLES; k++) begin
                  if (r_count == CNT_W'(k)) begin
                     r_result[NIB_W*k +: NIB_W] <= fa_sum_i;
                  end
               end
               r_carry <= fa_cout_i;
               r_count <= r_count + CNT_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

   // Next-state decode and output drive; adder inputs are zero outside ADD.
   always_comb begin
      w_next_state = r_state;
      nib_ready_o  = 1'b0;
      fa_a_o       = '0;
      fa_b_o       = '0;
      fa_cin_o     = 1'b0;
      done_o       = 1'b0;
      busy_o       = 1'b1;
      case (r_state)
         IDLE: begin
            busy_o = 1'b0;
            if (start_i) begin
               w_next_state = LOAD;
            end else begin
               w_next_state = IDLE;
            end
         end
         LOAD: begin
            nib_ready_o = 1'b1;
            if (nib_valid_i) begin
               w_next_state = ADD;
            end else begin
               w_next_state = LOAD;
            end
         end
         ADD: begin
            fa_a_o   = r_a;
            fa_b_o   = r_b;
            fa_cin_o = r_carry;
            if (r_count == LAST_CNT) begin
               w_next_state = DONE;
            end else begin
               w_next_state = LOAD;
            end
         end
         DONE: begin
            done_o       = 1'b1;
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   assign result_o = r_result;
   assign carry_o  = r_carry;

endmodule
